// File: rtl/router_input_unit.sv
// Router input port: flit FIFO, XY route computation and wormhole route lock.
// Optional ROUTER_INPUT_BYPASS_EN presents an arriving flit on the outputs when the FIFO is empty.
module router_input_unit #(
  parameter int FLIT_W  = 34,
  parameter int DEPTH   = 4,
  parameter int X_W     = 3,
  parameter int Y_W     = 3,
  parameter int NUM_OUT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_W-1:0]     my_x,
  input  logic [Y_W-1:0]     my_y,
  input  logic [FLIT_W-1:0]  in_flit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] request,
  input  logic [NUM_OUT-1:0] grant,
  output logic [FLIT_W-1:0]  out_flit,
  output logic               forwarding_head,
  output logic               forwarding_tail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] RT_LOCAL = 3'd0;
  localparam logic [2:0] RT_NORTH = 3'd1;
  localparam logic [2:0] RT_SOUTH = 3'd2;
  localparam logic [2:0] RT_EAST  = 3'd3;
  localparam logic [2:0] RT_WEST  = 3'd4;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              route_locked_q, route_locked_d;
  logic [2:0]        route_q, route_d;

  logic              fifo_empty, bypass, front_valid, front_head, front_tail;
  logic [FLIT_W-1:0] front_flit;
  logic [X_W-1:0]    dst_x;
  logic [Y_W-1:0]    dst_y;
  logic [2:0]        route_calc;
  logic              drop, fwd, consume, push, fifo_pop;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [2:0] idx);
    logic [NUM_OUT-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CW'(DEPTH));

`ifdef ROUTER_INPUT_BYPASS_EN
  assign bypass = fifo_empty & in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign front_valid = ~fifo_empty | bypass;
  assign front_flit  = bypass ? in_flit : mem_q[rd_ptr_q];
  assign front_head  = front_flit[FLIT_W-1];
  assign front_tail  = front_flit[FLIT_W-2];
  assign dst_x       = front_flit[X_W-1:0];
  assign dst_y       = front_flit[X_W+Y_W-1:X_W];

  always_comb begin
    route_calc = RT_LOCAL;
    if (dst_x > my_x)      route_calc = RT_EAST;
    else if (dst_x < my_x) route_calc = RT_WEST;
    else if (dst_y > my_y) route_calc = RT_NORTH;
    else if (dst_y < my_y) route_calc = RT_SOUTH;
  end

  // A head arriving while locked means the previous tail went missing: stall until reset.
  always_comb begin
    request = '0;
    if (front_valid) begin
      if (route_locked_q) begin
        if (!front_head) request = onehot(route_q);
      end else if (front_head) begin
        request = onehot(route_calc);
      end
    end
  end

  assign drop     = front_valid & ~route_locked_q & ~front_head;
  assign fwd      = |(request & grant);
  assign consume  = fwd | drop;
  assign fifo_pop = consume & ~bypass;
  assign push     = in_valid & in_ready & ~(bypass & consume);

  assign out_flit        = front_valid ? front_flit : '0;
  assign forwarding_head = fwd & front_head;
  assign forwarding_tail = fwd & front_tail;

  always_comb begin
    wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d        = count_q;
    route_locked_d = route_locked_q;
    route_d        = route_q;
    case ({push, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (fwd && front_tail) begin
      route_locked_d = 1'b0;
    end else if (fwd && front_head) begin
      route_locked_d = 1'b1;
      route_d        = route_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      route_locked_q <= 1'b0;
      route_q        <= RT_LOCAL;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      route_locked_q <= route_locked_d;
      route_q        <= route_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

endmodule
